// File: rtl/vsm_mem_master.sv
// Single-port memory master: turns a level CPU request into a
// setup / strobe / hold access sequence on an 8-word x 4-bit memory.
module vsm_mem_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       CpuReq,
    input  logic       CpuWr,
    input  logic [2:0] CpuAddr,
    input  logic [3:0] CpuWData,
    output logic [3:0] CpuRData,
    output logic       CpuAck,
    output logic       Busy,
    output logic [2:0] MemAddr,
    output logic [3:0] Mem_In,
    output logic       ReadMem,
    output logic       WriteMem,
    input  logic [3:0] Mem_Out
);

    // state  | meaning
    // IDLE   | waiting for CpuReq; address/data buses keep last access
    // SETUP  | one cycle of address/data settle, strobes low
    // STROBE | ReadMem or WriteMem high for STROBE_CYCLES cycles
    // HOLD   | strobes low, buses held; CpuAck in the last cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       wr_q;

    // The counter is shared: it times the strobe, then is reloaded for hold.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wr_q     <= 1'b0;
            CpuRData <= 4'd0;
            CpuAck   <= 1'b0;
            Busy     <= 1'b0;
            MemAddr  <= 3'd0;
            Mem_In   <= 4'd0;
            ReadMem  <= 1'b0;
            WriteMem <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CpuReq) begin
                        wr_q    <= CpuWr;
                        MemAddr <= CpuAddr;
                        Mem_In  <= CpuWData;
                        Busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    cnt      <= STROBE_LOAD;
                    ReadMem  <= ~wr_q;
                    WriteMem <= wr_q;
                    state    <= STROBE;
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        ReadMem  <= 1'b0;
                        WriteMem <= 1'b0;
                        if (!wr_q) begin
                            CpuRData <= Mem_Out;
                        end
                        cnt    <= HOLD_LOAD;
                        CpuAck <= (HOLD_LOAD == 4'd0);
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        CpuAck <= 1'b0;
                        Busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt    <= cnt - 4'd1;
                        CpuAck <= (cnt == 4'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vsm_mem_master.sv
// Directed bench for vsm_mem_master: default instance plus a
// STROBE_CYCLES=1 / HOLD_CYCLES=3 instance sharing the bus inputs.
module tb_vsm_mem_master;

    logic       clk;
    logic       rst_n;
    logic       cpu_req_a, cpu_req_b;
    logic       cpu_wr;
    logic [2:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic [3:0] mem_out;

    logic [3:0] rdata_a, rdata_b;
    logic       ack_a, ack_b, busy_a, busy_b;
    logic [2:0] maddr_a, maddr_b;
    logic [3:0] min_a, min_b;
    logic       rd_a, rd_b, wr_a, wr_b;

    int vectors = 0;
    int errors  = 0;

    vsm_mem_master dut_a (
        .Clk(clk), .Rst_n(rst_n), .CpuReq(cpu_req_a), .CpuWr(cpu_wr),
        .CpuAddr(cpu_addr), .CpuWData(cpu_wdata), .CpuRData(rdata_a),
        .CpuAck(ack_a), .Busy(busy_a), .MemAddr(maddr_a), .Mem_In(min_a),
        .ReadMem(rd_a), .WriteMem(wr_a), .Mem_Out(mem_out)
    );

    vsm_mem_master #(.STROBE_CYCLES(1), .HOLD_CYCLES(3)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .CpuReq(cpu_req_b), .CpuWr(cpu_wr),
        .CpuAddr(cpu_addr), .CpuWData(cpu_wdata), .CpuRData(rdata_b),
        .CpuAck(ack_b), .Busy(busy_b), .MemAddr(maddr_b), .Mem_In(min_b),
        .ReadMem(rd_b), .WriteMem(wr_b), .Mem_Out(mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request so that the next rising edge is edge 0.
    task automatic issue(input logic sel_b, input logic wr, input logic [2:0] addr,
                         input logic [3:0] wdata);
        @(negedge clk);
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        if (sel_b) cpu_req_b = 1'b1;
        else       cpu_req_a = 1'b1;
        @(posedge clk);
        #1;
        cpu_req_a = 1'b0;
        cpu_req_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({rdata_a, ack_a, busy_a, maddr_a, min_a, rd_a, wr_a} !== 17'd0) begin
            errors++;
            $display("FAIL reset_a got %h exp 0", {rdata_a, ack_a, busy_a, maddr_a, min_a, rd_a, wr_a});
        end
        vectors++;
        if ({rdata_b, ack_b, busy_b, maddr_b, min_b, rd_b, wr_b} !== 17'd0) begin
            errors++;
            $display("FAIL reset_b got %h exp 0", {rdata_b, ack_b, busy_b, maddr_b, min_b, rd_b, wr_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        mem_out = 4'h6;
        issue(1'b0, 1'b0, 3'd3, 4'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (rd_a !== (k == 2 || k == 3)) begin
                errors++; $display("FAIL read_strobe c%0d got %b exp %b", k, rd_a, (k == 2 || k == 3));
            end
            vectors++;
            if (wr_a !== 1'b0) begin
                errors++; $display("FAIL read_wrstrobe c%0d got %b exp 0", k, wr_a);
            end
            vectors++;
            if (ack_a !== (k == 4)) begin
                errors++; $display("FAIL read_ack c%0d got %b exp %b", k, ack_a, (k == 4));
            end
            vectors++;
            if (busy_a !== (k <= 4)) begin
                errors++; $display("FAIL read_busy c%0d got %b exp %b", k, busy_a, (k <= 4));
            end
            vectors++;
            if (maddr_a !== 3'd3) begin
                errors++; $display("FAIL read_addr c%0d got %0d exp 3", k, maddr_a);
            end
            if (k == 3) begin
                vectors++;
                if (rdata_a !== 4'h0) begin
                    errors++; $display("FAIL read_early c%0d got %h exp 0", k, rdata_a);
                end
            end
            if (k == 4) begin
                vectors++;
                if (rdata_a !== 4'h6) begin
                    errors++; $display("FAIL read_data c%0d got %h exp 6", k, rdata_a);
                end
            end
        end
    endtask

    task automatic test_write();
        mem_out = 4'hC;
        issue(1'b0, 1'b1, 3'd5, 4'hA);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (maddr_a !== 3'd5 || min_a !== 4'hA) begin
                errors++; $display("FAIL write_bus c%0d got %0d/%h exp 5/a", k, maddr_a, min_a);
            end
            vectors++;
            if (wr_a !== (k == 2 || k == 3)) begin
                errors++; $display("FAIL write_strobe c%0d got %b exp %b", k, wr_a, (k == 2 || k == 3));
            end
            vectors++;
            if (rd_a !== 1'b0) begin
                errors++; $display("FAIL write_rdstrobe c%0d got %b exp 0", k, rd_a);
            end
            vectors++;
            if (ack_a !== (k == 4)) begin
                errors++; $display("FAIL write_ack c%0d got %b exp %b", k, ack_a, (k == 4));
            end
            vectors++;
            if (rdata_a !== 4'h6) begin
                errors++; $display("FAIL write_rdata c%0d got %h exp 6", k, rdata_a);
            end
        end
    endtask

    task automatic test_busy();
        int acks = 0;
        mem_out = 4'h9;
        issue(1'b0, 1'b0, 3'd3, 4'h0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ack_a === 1'b1) acks++;
            vectors++;
            if (maddr_a !== 3'd3) begin
                errors++; $display("FAIL busy_addr c%0d got %0d exp 3", k, maddr_a);
            end
            vectors++;
            if (ack_a !== (k == 4)) begin
                errors++; $display("FAIL busy_ack c%0d got %b exp %b", k, ack_a, (k == 4));
            end
            if (k == 2) begin
                cpu_addr  = 3'd7;
                cpu_req_a = 1'b1;
            end
            if (k == 3) cpu_req_a = 1'b0;
        end
        vectors++;
        if (acks != 1) begin
            errors++; $display("FAIL busy_ackcount got %0d exp 1", acks);
        end
        vectors++;
        if (rdata_a !== 4'h9) begin
            errors++; $display("FAIL busy_rdata got %h exp 9", rdata_a);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        mem_out = 4'h2;
        @(negedge clk);
        cpu_wr    = 1'b0;
        cpu_addr  = 3'd1;
        cpu_req_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (ack_a === 1'b1) acks++;
            vectors++;
            if (ack_a !== (k == 4 || k == 9 || k == 14)) begin
                errors++; $display("FAIL b2b_ack c%0d got %b exp %b", k, ack_a, (k == 4 || k == 9 || k == 14));
            end
            vectors++;
            if ((rd_a & wr_a) !== 1'b0) begin
                errors++; $display("FAIL b2b_overlap c%0d got rd=%b wr=%b exp not both", k, rd_a, wr_a);
            end
            vectors++;
            if (rd_a !== (k % 5 == 2 || k % 5 == 3)) begin
                errors++; $display("FAIL b2b_strobe c%0d got %b exp %b", k, rd_a, (k % 5 == 2 || k % 5 == 3));
            end
            if (k == 11) cpu_req_a = 1'b0;
        end
        vectors++;
        if (acks != 3) begin
            errors++; $display("FAIL b2b_ackcount got %0d exp 3", acks);
        end
        vectors++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got %b exp 0", busy_a);
        end
    endtask

    task automatic test_mid_reset();
        issue(1'b0, 1'b1, 3'd2, 4'h5);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (wr_a !== 1'b1) begin
            errors++; $display("FAIL rst_prestrobe got %b exp 1", wr_a);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (wr_a !== 1'b0) begin
            errors++; $display("FAIL rst_async_strobe got %b exp 0", wr_a);
        end
        vectors++;
        if ({rdata_a, ack_a, busy_a, maddr_a, min_a, rd_a, wr_a} !== 17'd0) begin
            errors++; $display("FAIL rst_outputs got %h exp 0", {rdata_a, ack_a, busy_a, maddr_a, min_a, rd_a, wr_a});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (ack_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++; $display("FAIL rst_held c%0d got ack=%b busy=%b exp 0/0", k, ack_a, busy_a);
            end
        end
        rst_n = 1'b1;
        mem_out = 4'h3;
        issue(1'b0, 1'b0, 3'd6, 4'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if (ack_a !== (k == 4) || rd_a !== (k == 2 || k == 3)) begin
                errors++; $display("FAIL rst_read c%0d got ack=%b rd=%b exp %b/%b", k, ack_a, rd_a, (k == 4), (k == 2 || k == 3));
            end
            if (k == 4) begin
                vectors++;
                if (rdata_a !== 4'h3 || maddr_a !== 3'd6) begin
                    errors++; $display("FAIL rst_read_data got %h@%0d exp 3@6", rdata_a, maddr_a);
                end
            end
        end
    endtask

    task automatic test_params();
        int strobes = 0;
        mem_out = 4'hF;
        issue(1'b1, 1'b0, 3'd4, 4'h0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (rd_b === 1'b1) strobes++;
            vectors++;
            if (rd_b !== (k == 2) || wr_b !== 1'b0) begin
                errors++; $display("FAIL param_strobe c%0d got rd=%b wr=%b exp %b/0", k, rd_b, wr_b, (k == 2));
            end
            vectors++;
            if (ack_b !== (k == 5)) begin
                errors++; $display("FAIL param_ack c%0d got %b exp %b", k, ack_b, (k == 5));
            end
            vectors++;
            if (busy_b !== (k <= 5)) begin
                errors++; $display("FAIL param_busy c%0d got %b exp %b", k, busy_b, (k <= 5));
            end
            if (k == 3) begin
                vectors++;
                if (rdata_b !== 4'hF) begin
                    errors++; $display("FAIL param_rdata got %h exp f", rdata_b);
                end
            end
        end
        vectors++;
        if (strobes != 1) begin
            errors++; $display("FAIL param_strobecount got %0d exp 1", strobes);
        end
    endtask

    initial begin
        cpu_req_a = 1'b0;
        cpu_req_b = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 3'd0;
        cpu_wdata = 4'h0;
        mem_out   = 4'h0;
        test_reset();
        test_read();
        test_write();
        test_busy();
        test_back_to_back();
        test_mid_reset();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
